// File: rtl/voxel_frame_scheduler.sv
// voxel_frame_scheduler: per-frame sequencer and write arbiter for the shared
// framebuffer RAM write port. Each frame it optionally clears the buffer to a
// fixed colour, then hands the port to the voxel renderer until it reports
// done. CPU writes are interleaved round-robin throughout, and writes can be
// limited to the blanking interval.
module voxel_frame_scheduler #(
    parameter int AW         = 12,
    parameter int DW         = 8,
    parameter int BLANK_ONLY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          display_on,
    input  logic          clear_en,
    input  logic [DW-1:0] clear_color,
    input  logic          r_valid,
    input  logic [AW-1:0] r_addr,
    input  logic [DW-1:0] r_data,
    output logic          r_ready,
    output logic          r_start,
    input  logic          r_done,
    input  logic          c_valid,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_data,
    output logic          c_ready,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] ram_d,
    output logic          busy,
    output logic [7:0]    overrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RENDER = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] clear_color_q, clear_color_d;
    logic          rr_last_q, rr_last_d;      // 1: owner granted last, 0: CPU granted last
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          r_start_q, r_start_d;
    logic [7:0]    overrun_q, overrun_d;

    logic win_s;
    logic owner_req_s;
    logic grant_o_s;
    logic grant_c_s;
    logic busy_s;

    // Write window and round-robin arbitration between the phase owner and the CPU
    always_comb begin
        win_s       = (BLANK_ONLY != 0) ? !display_on : 1'b1;
        owner_req_s = (state_q == S_CLEAR) || ((state_q == S_RENDER) && r_valid);
        grant_o_s   = 1'b0;
        grant_c_s   = 1'b0;
        if (!win_s) begin
            grant_o_s = 1'b0;
            grant_c_s = 1'b0;
        end else if (owner_req_s && c_valid) begin
            // Contention: whoever was not served last goes first
            grant_o_s = !rr_last_q;
            grant_c_s = rr_last_q;
        end else if (owner_req_s) begin
            grant_o_s = 1'b1;
        end else if (c_valid) begin
            grant_c_s = 1'b1;
        end else begin
            grant_o_s = 1'b0;
            grant_c_s = 1'b0;
        end
        busy_s = (state_q == S_CLEAR) || (state_q == S_RENDER);
    end

    // Next-state, write-port and counter computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        clear_color_d = clear_color_q;
        rr_last_d     = rr_last_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        ram_d_d       = ram_d_q;
        r_start_d     = 1'b0;
        overrun_d     = overrun_q;

        // Granted write is presented on the RAM port one cycle later
        if (grant_o_s) begin
            rr_last_d = 1'b1;
            we_d      = 1'b1;
            if (state_q == S_CLEAR) begin
                addr_d  = cnt_q;
                ram_d_d = clear_color_q;
            end else begin
                addr_d  = r_addr;
                ram_d_d = r_data;
            end
        end else if (grant_c_s) begin
            rr_last_d = 1'b0;
            we_d      = 1'b1;
            addr_d    = c_addr;
            ram_d_d   = c_data;
        end else begin
            we_d = 1'b0;
        end

        // A frame_start that arrives while a frame is still in progress is dropped and counted
        if (busy_s && frame_start && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (frame_start) begin
                    clear_color_d = clear_color;
                    cnt_d         = {AW{1'b0}};
                    if (clear_en) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d   = S_RENDER;
                        r_start_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_CLEAR: begin
                if (grant_o_s) begin
                    cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                    if (cnt_q == {AW{1'b1}}) begin
                        state_d   = S_RENDER;
                        r_start_d = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_RENDER: begin
                if (r_done) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RENDER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, dropping any pending write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= {AW{1'b0}};
            clear_color_q <= {DW{1'b0}};
            rr_last_q     <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= {AW{1'b0}};
            ram_d_q       <= {DW{1'b0}};
            r_start_q     <= 1'b0;
            overrun_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            clear_color_q <= clear_color_d;
            rr_last_q     <= rr_last_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            ram_d_q       <= ram_d_d;
            r_start_q     <= r_start_d;
            overrun_q     <= overrun_d;
        end
    end

    assign r_ready     = grant_o_s && (state_q == S_RENDER);
    assign c_ready     = grant_c_s;
    assign r_start     = r_start_q;
    assign we          = we_q;
    assign addr        = addr_q;
    assign ram_d       = ram_d_q;
    assign busy        = busy_s;
    assign overrun_cnt = overrun_q;

endmodule
